mac_row: RTL and testbench

- One row of a weight-stationary systolic MAC array: `col` identical MAC tiles chained west to east.
- Activations/weights (`in_w`) and the instruction (`inst_w`) enter at the west edge and ripple one tile per cycle.
- Each tile holds one stationary weight. It adds activation×weight to the partial sum from the north (`in_n` slice) and drives the result south (`out_s` slice), with a per-column `valid` flag.

---
 rtl/mac_row_pkg.sv | 13 +
 rtl/mac_tile.sv | 69 ++++++
 rtl/mac_row.sv | 54 +++++
 tb/tb_mac_row.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_row_pkg.sv
// Shared widths and instruction bit positions for the MAC row.
package mac_row_pkg;

    localparam int unsigned BW        = 4;
    localparam int unsigned PSUM_BW   = 16;
    localparam int unsigned COL       = 8;
    localparam int unsigned INST_W    = 2;

    // Instruction bit positions on inst_w / inst_q
    localparam int unsigned INST_LOAD = 0;
    localparam int unsigned INST_EXEC = 1;

endpackage

// File: rtl/mac_tile.sv
// One weight-stationary MAC tile: holds a weight, forwards activation and
// instruction east, and produces unsigned(act) * signed(weight) + north psum.
module mac_tile
    import mac_row_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned psum_bw = PSUM_BW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bw-1:0]       i_a,
    input  logic [INST_W-1:0]   i_inst,
    input  logic [psum_bw-1:0]  i_psum,
    output logic [bw-1:0]       o_a,
    output logic [INST_W-1:0]   o_inst,
    output logic [psum_bw-1:0]  o_psum_c,
    output logic                o_valid
);

    localparam int unsigned PROD_W = 2 * bw + 1;

    logic [bw-1:0]       r_a;
    logic [bw-1:0]       r_b;
    logic [psum_bw-1:0]  r_c;
    logic [INST_W-1:0]   r_inst;
    logic                r_load_ready;

    logic signed [bw:0]       w_a_s;
    logic signed [bw-1:0]     w_b_s;
    logic signed [PROD_W-1:0] w_prod;
    logic [psum_bw-1:0]       w_prod_ext;

    // Tile state: weight captured once, load token held back until the weight is in
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_inst       <= '0;
            r_load_ready <= 1'b1;
        end else begin
            r_c               <= i_psum;
            r_inst[INST_EXEC] <= i_inst[INST_EXEC];
            if (|i_inst) begin
                r_a <= i_a;
            end
            if (i_inst[INST_LOAD] && r_load_ready) begin
                r_b          <= i_a;
                r_load_ready <= 1'b0;
            end
            // Load only propagates east once this tile's slot is filled
            if (!r_load_ready) begin
                r_inst[INST_LOAD] <= i_inst[INST_LOAD];
            end
        end
    end

    // Activation is zero-extended to stay non-negative; weight is two's complement
    assign w_a_s      = {1'b0, r_a};
    assign w_b_s      = r_b;
    assign w_prod     = PROD_W'(w_a_s) * PROD_W'(w_b_s);
    assign w_prod_ext = {{(psum_bw - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    assign o_psum_c = w_prod_ext + r_c;
    assign o_a      = r_a;
    assign o_inst   = r_inst;
    assign o_valid  = r_inst[INST_EXEC];

endmodule

// File: rtl/mac_row.sv
// One row of a weight-stationary systolic array: col MAC tiles chained west to east.
module mac_row
    import mac_row_pkg::*;
#(
    parameter int unsigned bw      = BW,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned col     = COL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bw-1:0]           in_w,
    input  logic [INST_W-1:0]       inst_w,
    input  logic [psum_bw*col-1:0]  in_n,
    output logic [psum_bw*col-1:0]  out_s,
    output logic [col-1:0]          valid
);

    logic [bw-1:0]     w_a_out    [col];
    logic [INST_W-1:0] w_inst_out [col];

    // The eastmost tile's forwarded data has no consumer
    logic [bw+INST_W-1:0] w_unused_east;
    assign w_unused_east = {w_a_out[col-1], w_inst_out[col-1]};

    // Tile chain with per-column psum slicing
    for (genvar g = 0; g < int'(col); g++) begin : g_tile
        logic [bw-1:0]     w_a_in;
        logic [INST_W-1:0] w_inst_in;

        if (g == 0) begin : g_west
            assign w_a_in    = in_w;
            assign w_inst_in = inst_w;
        end else begin : g_chain
            assign w_a_in    = w_a_out[g-1];
            assign w_inst_in = w_inst_out[g-1];
        end

        mac_tile #(
            .bw      (bw),
            .psum_bw (psum_bw)
        ) u_tile (
            .clk      (clk),
            .reset    (reset),
            .i_a      (w_a_in),
            .i_inst   (w_inst_in),
            .i_psum   (in_n[psum_bw*g +: psum_bw]),
            .o_a      (w_a_out[g]),
            .o_inst   (w_inst_out[g]),
            .o_psum_c (out_s[psum_bw*g +: psum_bw]),
            .o_valid  (valid[g])
        );
    end

endmodule

// File: tb/tb_mac_row.sv
// Directed bench for mac_row: reset, weight load, execute timing, valid drop,
// per-column weights, wrap-around arithmetic, reload lockout, reset mid-execute.
module tb_mac_row;

    localparam int unsigned BW      = 4;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned COL     = 8;
    localparam int unsigned BUS_W   = PSUM_BW * COL;

    logic               clk;
    logic               reset;
    logic [BW-1:0]      in_w;
    logic [1:0]         inst_w;
    logic [BUS_W-1:0]   in_n;
    logic [BUS_W-1:0]   out_s;
    logic [COL-1:0]     valid;

    int checks;
    int errors;

    mac_row #(
        .bw      (BW),
        .psum_bw (PSUM_BW),
        .col     (COL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .inst_w (inst_w),
        .in_n   (in_n),
        .out_s  (out_s),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] rep(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic do_reset();
        reset  = 1'b0;
        inst_w = 2'b00;
        in_w   = '0;
        in_n   = '0;
        step();
        reset  = 1'b1;
    endtask

    task automatic load_all(input logic [BW-1:0] w);
        inst_w = 2'b01;
        in_w   = w;
        for (int n = 0; n < 2 * int'(COL) - 1; n++) step();
        inst_w = 2'b00;
    endtask

    task automatic test_reset();
        logic [BUS_W-1:0] n_val;
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_w   = BW'($urandom);
            inst_w = 2'($urandom);
            for (int c = 0; c < int'(COL); c++) in_n[PSUM_BW*c +: PSUM_BW] = PSUM_BW'($urandom);
            step();
            checks++;
            if (out_s !== '0) begin
                errors++;
                $display("FAIL reset_out_s: got %h expected 0", out_s);
            end
            checks++;
            if (valid !== '0) begin
                errors++;
                $display("FAIL reset_valid: got %h expected 00", valid);
            end
        end
        reset  = 1'b1;
        inst_w = 2'b00;
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < int'(COL); c++) n_val[PSUM_BW*c +: PSUM_BW] = PSUM_BW'($urandom);
            in_n = n_val;
            step();
            checks++;
            if (out_s !== n_val) begin
                errors++;
                $display("FAIL idle_passthru: got %h expected %h", out_s, n_val);
            end
            checks++;
            if (valid !== '0) begin
                errors++;
                $display("FAIL idle_valid: got %h expected 00", valid);
            end
        end
    endtask

    // Load -6 everywhere, then execute a=5 over north psum 10 -> -20 per column
    task automatic test_load_execute();
        logic [COL-1:0] exp_v;
        do_reset();
        load_all(4'b1010);
        inst_w = 2'b10;
        in_w   = 4'd5;
        in_n   = rep(16'h000A);
        for (int n = 1; n <= int'(COL); n++) begin
            step();
            exp_v = COL'((1 << n) - 1);
            checks++;
            if (valid !== exp_v) begin
                errors++;
                $display("FAIL exec_valid_rise[%0d]: got %h expected %h", n, valid, exp_v);
            end
            for (int c = 0; c < n; c++) begin
                checks++;
                if (out_s[PSUM_BW*c +: PSUM_BW] !== 16'hFFEC) begin
                    errors++;
                    $display("FAIL exec_out_s col%0d cyc%0d: got %h expected ffec",
                             c, n, out_s[PSUM_BW*c +: PSUM_BW]);
                end
            end
        end
    endtask

    // Drop execute: valid clears west first, one column per cycle
    task automatic test_valid_drop();
        logic [COL-1:0] exp_v;
        inst_w = 2'b00;
        for (int n = 1; n <= int'(COL); n++) begin
            step();
            exp_v = COL'(8'hFF << n);
            checks++;
            if (valid !== exp_v) begin
                errors++;
                $display("FAIL valid_drop[%0d]: got %h expected %h", n, valid, exp_v);
            end
        end
        checks++;
        if (out_s !== rep(16'hFFEC)) begin
            errors++;
            $display("FAIL hold_out_s: got %h expected %h", out_s, rep(16'hFFEC));
        end
    endtask

    // Stream 1..8; the 4-bit pattern for 8 is -8 as a signed weight
    task automatic test_distinct_weights();
        logic [BW-1:0]      wv;
        logic [PSUM_BW-1:0] exp_s;
        int                 ws;
        do_reset();
        inst_w = 2'b01;
        for (int n = 0; n < 2 * int'(COL) - 1; n++) begin
            in_w = (n < int'(COL)) ? BW'(n + 1) : BW'(0);
            step();
        end
        inst_w = 2'b10;
        in_w   = 4'd3;
        in_n   = '0;
        for (int n = 0; n < int'(COL); n++) step();
        checks++;
        if (valid !== 8'hFF) begin
            errors++;
            $display("FAIL distinct_valid: got %h expected ff", valid);
        end
        for (int c = 0; c < int'(COL); c++) begin
            wv    = BW'(c + 1);
            ws    = int'($signed(wv));
            exp_s = PSUM_BW'(3 * ws);
            checks++;
            if (out_s[PSUM_BW*c +: PSUM_BW] !== exp_s) begin
                errors++;
                $display("FAIL distinct_out_s col%0d: got %h expected %h",
                         c, out_s[PSUM_BW*c +: PSUM_BW], exp_s);
            end
        end
    endtask

    // 15 * -8 + 0x8000 wraps to 0x7F88; reload must not change it; reset clears mid-execute
    task automatic test_extremes();
        do_reset();
        load_all(4'h8);
        inst_w = 2'b10;
        in_w   = 4'hF;
        in_n   = rep(16'h8000);
        for (int n = 0; n < int'(COL); n++) step();
        checks++;
        if (out_s !== rep(16'h7F88)) begin
            errors++;
            $display("FAIL wrap_out_s: got %h expected %h", out_s, rep(16'h7F88));
        end
        load_all(4'h3);
        inst_w = 2'b10;
        in_w   = 4'hF;
        for (int n = 0; n < int'(COL); n++) step();
        checks++;
        if (out_s !== rep(16'h7F88)) begin
            errors++;
            $display("FAIL reload_out_s: got %h expected %h", out_s, rep(16'h7F88));
        end
        checks++;
        if (valid !== 8'hFF) begin
            errors++;
            $display("FAIL reload_valid: got %h expected ff", valid);
        end
        reset = 1'b0;
        step();
        checks++;
        if (out_s !== '0) begin
            errors++;
            $display("FAIL midexec_reset_out_s: got %h expected 0", out_s);
        end
        checks++;
        if (valid !== '0) begin
            errors++;
            $display("FAIL midexec_reset_valid: got %h expected 00", valid);
        end
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        in_w   = '0;
        inst_w = 2'b00;
        in_n   = '0;
        #2;
        test_reset();
        test_load_execute();
        test_valid_drop();
        test_distinct_weights();
        test_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
